// File: rtl/power_integrate_pkg.sv
// Shared constants and helpers for the N-channel power integrator.
// Settings offsets are relative to the instance BASE address.
package power_integrate_pkg;

  localparam int SR_SCALE     = 0;
  localparam int SR_INTEGRATE = 1;
  localparam int SR_ENABLE    = 2;

  // Working width of the output scaler; accumulators up to this width are supported.
  localparam int FULL_W = 64;

  // Width of a channel tag; a single channel still needs one wire.
  function automatic int chan_width(input int num_chan);
    return (num_chan > 1) ? $clog2(num_chan) : 1;
  endfunction

  // Right-shift an accumulator and clamp it to the largest out_width-bit value.
  // Shifts past the accumulator's top bit give zero.
  function automatic logic [FULL_W-1:0] sat_shift(input logic [FULL_W-1:0] acc,
                                                  input logic [5:0]        scale,
                                                  input int                acc_width,
                                                  input int                out_width);
    logic [FULL_W-1:0] shifted;
    logic [FULL_W-1:0] limit;
    limit = (out_width >= FULL_W) ? '1 : ((FULL_W'(1) << out_width) - FULL_W'(1));
    if (int'(scale) > acc_width - 1)
      shifted = '0;
    else
      shifted = acc >> scale;
    return (shifted > limit) ? limit : shifted;
  endfunction

endpackage

// File: rtl/power_sq_sum.sv
// Square-and-sum front end: S1 registers I/Q, S2 squares, S3 adds.
// The channel tag and valid travel with the data; flush drops everything in flight.
module power_sq_sum
  import power_integrate_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               valid_in,
  input  logic [CW-1:0]      chan_in,
  input  logic [WIDTH-1:0]   i_in,
  input  logic [WIDTH-1:0]   q_in,
  output logic               valid_out,
  output logic [CW-1:0]      chan_out,
  output logic [2*WIDTH-1:0] sum_out
);

  localparam int SW = 2 * WIDTH;

  logic                    s1_valid, s2_valid;
  logic [CW-1:0]           s1_chan, s2_chan;
  logic signed [WIDTH-1:0] s1_i, s1_q;
  logic signed [SW-1:0]    i_ext, q_ext, ii_full, qq_full;
  logic [SW-2:0]           s2_ii, s2_qq;
  logic                    unused_sign;

  // Squares are computed at full width; the top bit is always zero since
  // even (-2^(W-1))^2 fits in 2W-1 bits.
  assign i_ext       = SW'(s1_i);
  assign q_ext       = SW'(s1_q);
  assign ii_full     = i_ext * i_ext;
  assign qq_full     = q_ext * q_ext;
  assign unused_sign = ii_full[SW-1] ^ qq_full[SW-1];

  // Three register stages with valid/tag passthrough; flush empties them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      valid_out <= 1'b0;
      s1_i      <= '0;
      s1_q      <= '0;
      s1_chan   <= '0;
      s2_ii     <= '0;
      s2_qq     <= '0;
      s2_chan   <= '0;
      sum_out   <= '0;
      chan_out  <= '0;
    end else begin
      s1_valid  <= valid_in && !flush;
      s2_valid  <= s1_valid && !flush;
      valid_out <= s2_valid && !flush;
      s1_i      <= i_in;
      s1_q      <= q_in;
      s1_chan   <= chan_in;
      s2_ii     <= ii_full[SW-2:0];
      s2_qq     <= qq_full[SW-2:0];
      s2_chan   <= s1_chan;
      sum_out   <= {1'b0, s2_ii} + {1'b0, s2_qq};
      chan_out  <= s2_chan;
    end
  end

endmodule

// File: rtl/power_integrate_nchan.sv
// N-channel interleaved power integrator: sums |I|^2+|Q|^2 per channel over
// 'integrate' samples and emits a scaled, saturated power word per period.
// Build option: define POWER_INTEGRATE_PEAK_HOLD_EN to build peak tracking.
module power_integrate_nchan
  import power_integrate_pkg::*;
#(
  parameter int BASE      = 0,
  parameter int WIDTH     = 16,
  parameter int NUM_CHAN  = 1,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              run,
  input  logic                              set_stb,
  input  logic [7:0]                        set_addr,
  input  logic [31:0]                       set_data,
  input  logic [WIDTH-1:0]                  i_in,
  input  logic [WIDTH-1:0]                  q_in,
  input  logic [chan_width(NUM_CHAN)-1:0]   chan_in,
  input  logic                              strobe_in,
  output logic [OUT_WIDTH-1:0]              power_out,
  output logic [chan_width(NUM_CHAN)-1:0]   chan_out,
  output logic [OUT_WIDTH-1:0]              peak_out,
  output logic                              overflow_out,
  output logic                              strobe_out
);

  localparam int CW = chan_width(NUM_CHAN);
  localparam int SW = 2 * WIDTH;

  logic [5:0]  scale;
  logic [15:0] integrate, integ_eff;
  logic        enable, en_toggle, clear, sq_valid;
  logic        unused_bits;

  // Dropping run or flipping enable restarts every channel and empties the pipe.
  assign en_toggle = set_stb && (set_addr == 8'(BASE + SR_ENABLE)) && (set_data[0] != enable);
  assign clear     = !run || en_toggle;
  assign integ_eff = (integrate == 16'd0) ? 16'd1 : integrate;
  assign sq_valid  = strobe_in && enable && (32'(chan_in) < NUM_CHAN);

  // Settings-bus registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scale     <= '0;
      integrate <= '0;
      enable    <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == 8'(BASE + SR_SCALE))     scale     <= set_data[5:0];
      if (set_addr == 8'(BASE + SR_INTEGRATE)) integrate <= set_data[15:0];
      if (set_addr == 8'(BASE + SR_ENABLE))    enable    <= set_data[0];
    end
  end

  logic          s3_valid;
  logic [CW-1:0] s3_chan;
  logic [SW-1:0] s3_sum;

  power_sq_sum #(.WIDTH(WIDTH), .CW(CW)) u_sq_sum (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .valid_in  (sq_valid),
    .chan_in   (chan_in),
    .i_in      (i_in),
    .q_in      (q_in),
    .valid_out (s3_valid),
    .chan_out  (s3_chan),
    .sum_out   (s3_sum)
  );

  // Per-channel state; 'primed' is the complement of the first-sample flag so
  // that reset clears it like every other register.
  logic [ACC_WIDTH-1:0] acc_rd    [0:NUM_CHAN-1];
  logic [15:0]          count_rd  [0:NUM_CHAN-1];
  logic                 ovf_rd    [0:NUM_CHAN-1];
  logic                 primed_rd [0:NUM_CHAN-1];

  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] new_acc;
  logic [15:0]          new_count;
  logic                 new_ovf, dump;

  // S4 read-modify-write of the channel carried by the S3 sample.
  always_comb begin
    acc_sum   = {1'b0, acc_rd[s3_chan]} + (ACC_WIDTH+1)'(s3_sum);
    new_acc   = acc_sum[ACC_WIDTH-1:0];
    new_ovf   = ovf_rd[s3_chan];
    new_count = count_rd[s3_chan] + 16'd1;
    if (!primed_rd[s3_chan]) begin
      new_acc   = ACC_WIDTH'(s3_sum);
      new_ovf   = 1'b0;
      new_count = 16'd1;
    end else if (acc_sum[ACC_WIDTH]) begin
      new_acc = '1;
      new_ovf = 1'b1;
    end
    dump = new_count >= integ_eff;
  end

`ifdef POWER_INTEGRATE_PEAK_HOLD_EN
  logic [SW-1:0] peak_rd [0:NUM_CHAN-1];
  logic [SW-1:0] new_peak;

  // Running maximum of the instantaneous power for the S3 sample's channel.
  always_comb begin
    new_peak = peak_rd[s3_chan];
    if (!primed_rd[s3_chan] || (s3_sum > new_peak)) new_peak = s3_sum;
  end
`endif

  genvar gi;
  for (gi = 0; gi < NUM_CHAN; gi = gi + 1) begin : g_chan
    logic [ACC_WIDTH-1:0] acc;
    logic [15:0]          count;
    logic                 ovf, primed, hit;

    assign hit = s3_valid && (s3_chan == CW'(gi));

    // One channel's totals; a dump leaves it unprimed for the next period.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc    <= '0;
        count  <= '0;
        ovf    <= 1'b0;
        primed <= 1'b0;
      end else if (clear) begin
        count  <= '0;
        primed <= 1'b0;
      end else if (hit) begin
        acc    <= new_acc;
        count  <= new_count;
        ovf    <= new_ovf;
        primed <= !dump;
      end
    end

    assign acc_rd[gi]    = acc;
    assign count_rd[gi]  = count;
    assign ovf_rd[gi]    = ovf;
    assign primed_rd[gi] = primed;

`ifdef POWER_INTEGRATE_PEAK_HOLD_EN
    logic [SW-1:0] peak;

    // This channel's peak, updated alongside its accumulator.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)              peak <= '0;
      else if (!clear && hit) peak <= new_peak;
    end

    assign peak_rd[gi] = peak;
`endif
  end

  logic                 s4_valid, s4_ovf;
  logic [CW-1:0]        s4_chan;
  logic [ACC_WIDTH-1:0] s4_acc;
  logic [FULL_W-1:0]    shifted_full;

  assign shifted_full = sat_shift(FULL_W'(s4_acc), scale, ACC_WIDTH, OUT_WIDTH);
  assign unused_bits  = ^{set_data[31:16], shifted_full[FULL_W-1:OUT_WIDTH]};

`ifdef POWER_INTEGRATE_PEAK_HOLD_EN
  logic [SW-1:0] s4_peak;

  // Snapshot of the dumping channel's peak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 s4_peak <= '0;
    else if (s3_valid && dump) s4_peak <= new_peak;
  end
`endif

  // S4 snapshot of the dumping channel, so the channel itself can restart at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s4_valid <= 1'b0;
      s4_chan  <= '0;
      s4_acc   <= '0;
      s4_ovf   <= 1'b0;
    end else begin
      s4_valid <= s3_valid && dump && !clear;
      if (s3_valid && dump) begin
        s4_chan <= s3_chan;
        s4_acc  <= new_acc;
        s4_ovf  <= new_ovf;
      end
    end
  end

  // S5 output register: bypass passes raw samples, otherwise scaled period results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      power_out    <= '0;
      chan_out     <= '0;
      overflow_out <= 1'b0;
      strobe_out   <= 1'b0;
`ifdef POWER_INTEGRATE_PEAK_HOLD_EN
      peak_out     <= '0;
`endif
    end else if (!enable) begin
      power_out    <= OUT_WIDTH'({i_in, q_in});
      chan_out     <= chan_in;
      overflow_out <= 1'b0;
      strobe_out   <= strobe_in;
`ifdef POWER_INTEGRATE_PEAK_HOLD_EN
      peak_out     <= '0;
`endif
    end else begin
      strobe_out <= s4_valid && !clear;
      if (s4_valid) begin
        power_out    <= shifted_full[OUT_WIDTH-1:0];
        chan_out     <= s4_chan;
        overflow_out <= s4_ovf;
`ifdef POWER_INTEGRATE_PEAK_HOLD_EN
        peak_out     <= OUT_WIDTH'(s4_peak);
`endif
      end
    end
  end

`ifndef POWER_INTEGRATE_PEAK_HOLD_EN
  assign peak_out = '0;
`endif

endmodule

// File: tb/tb_power_integrate_nchan.sv
// Directed bench for power_integrate_nchan: a 3-channel instance with default
// widths plus a 1-channel instance with a 34-bit accumulator for saturation.
`timescale 1ns/1ps
module tb_power_integrate_nchan;

`ifdef POWER_INTEGRATE_PEAK_HOLD_EN
  localparam bit PEAK_BUILT = 1'b1;
`else
  localparam bit PEAK_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, run, set_stb, strobe_in;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [15:0] i_in, q_in;
  logic [1:0]  chan_in;
  logic [0:0]  chan_s;

  logic [31:0] power_out, peak_out, power_s, peak_s;
  logic [1:0]  chan_out;
  logic [0:0]  chan_s_out;
  logic        overflow_out, strobe_out, ovf_s, strobe_s;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  power_integrate_nchan #(.NUM_CHAN(3)) dut (
    .clk(clk), .reset(reset), .run(run), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .i_in(i_in), .q_in(q_in), .chan_in(chan_in),
    .strobe_in(strobe_in), .power_out(power_out), .chan_out(chan_out),
    .peak_out(peak_out), .overflow_out(overflow_out), .strobe_out(strobe_out)
  );

  power_integrate_nchan #(.NUM_CHAN(1), .ACC_WIDTH(34)) dut_s (
    .clk(clk), .reset(reset), .run(run), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .i_in(i_in), .q_in(q_in), .chan_in(chan_s),
    .strobe_in(strobe_in), .power_out(power_s), .chan_out(chan_s_out),
    .peak_out(peak_s), .overflow_out(ovf_s), .strobe_out(strobe_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] pwr, input logic [1:0] ch,
                           input logic ovf, input logic [31:0] pk);
    check({tag, ".strobe"}, 64'(strobe_out), 64'd1);
    check({tag, ".power"}, 64'(power_out), 64'(pwr));
    check({tag, ".chan"}, 64'(chan_out), 64'(ch));
    check({tag, ".ovf"}, 64'(overflow_out), 64'(ovf));
    check({tag, ".peak"}, 64'(peak_out), PEAK_BUILT ? 64'(pk) : 64'd0);
    $display("txn %s: power=0x%08h chan=%0d ovf=%0d peak=%0d", tag, power_out, chan_out,
             overflow_out, peak_out);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".idle"}, 64'(strobe_out), 64'd0);
  endtask

  // Present one sample (or an idle cycle) and step past the capturing edge.
  task automatic drive(input logic [15:0] i, input logic [15:0] q, input logic [1:0] ch,
                       input logic stb);
    i_in = i; q_in = q; chan_in = ch; strobe_in = stb;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(16'd0, 16'd0, 2'd0, 1'b0);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    strobe_in = 1'b0; set_stb = 1'b1; set_addr = addr; set_data = data;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    i_in = '0; q_in = '0; chan_in = '0; chan_s = '0; strobe_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.power", 64'(power_out), 64'd0);
    check("rst.chan", 64'(chan_out), 64'd0);
    check("rst.peak", 64'(peak_out), 64'd0);
    check("rst.ovf", 64'(overflow_out), 64'd0);
    check("rst.strobe", 64'(strobe_out), 64'd0);
    reset = 1'b0; run = 1'b1;
    idle();

    // Four full-scale-half I samples: 4 * 2^28 >> 2 = 2^28, five cycles after the last.
    wr(8'd0, 32'd2); wr(8'd1, 32'd4); wr(8'd2, 32'd1);
    repeat (4) drive(16'd16384, 16'd0, 2'd0, 1'b1);
    repeat (3) begin idle(); check_idle("t1.lat"); end
    idle();
    check_out("t1", 32'h1000_0000, 2'd0, 1'b0, 32'h1000_0000);
    check("t1.s.power", 64'(power_s), 64'h1000_0000);
    idle(); check_idle("t1.width");

    // Interleaved channels, plus an out-of-range tag that must be ignored.
    wr(8'd1, 32'd2); wr(8'd0, 32'd0);
    drive(16'd1, 16'd1, 2'd0, 1'b1);
    drive(16'd2, 16'd0, 2'd1, 1'b1);
    drive(16'd100, 16'd100, 2'd3, 1'b1);
    drive(16'd1, 16'd1, 2'd0, 1'b1);
    drive(16'd2, 16'd0, 2'd1, 1'b1);
    repeat (2) begin idle(); check_idle("t2.lat"); end
    idle(); check_out("t2.ch0", 32'd4, 2'd0, 1'b0, 32'd2);
    idle(); check_out("t2.ch1", 32'd8, 2'd1, 1'b0, 32'd4);
    idle(); check_idle("t2.width");

    // Peak hold: sums 1, 90000, 4.
    wr(8'd1, 32'd3);
    drive(16'd1, 16'd0, 2'd0, 1'b1);
    drive(16'd300, 16'd0, 2'd0, 1'b1);
    drive(16'd2, 16'd0, 2'd0, 1'b1);
    repeat (3) begin idle(); check_idle("t3.lat"); end
    idle(); check_out("t3", 32'd90005, 2'd0, 1'b0, 32'd90000);

    // run dropped mid-period: nothing comes out, next period starts fresh (4 * 25).
    wr(8'd1, 32'd4);
    repeat (2) drive(16'd10, 16'd0, 2'd0, 1'b1);
    run = 1'b0;
    repeat (2) begin idle(); check_idle("t4.runlow"); end
    run = 1'b1;
    repeat (4) begin idle(); check_idle("t4.after"); end
    repeat (4) drive(16'd3, 16'd4, 2'd0, 1'b1);
    repeat (3) begin idle(); check_idle("t4.lat"); end
    idle(); check_out("t4", 32'd100, 2'd0, 1'b0, 32'd25);
    idle(); check_idle("t4.width");

    // Bypass: raw {I,Q} one cycle later, independent of run.
    wr(8'd2, 32'd0);
    drive(16'h1234, 16'hABCD, 2'd2, 1'b1);
    check("t5.strobe", 64'(strobe_out), 64'd1);
    check("t5.power", 64'(power_out), 64'h1234_ABCD);
    check("t5.chan", 64'(chan_out), 64'd2);
    check("t5.peak", 64'(peak_out), 64'd0);
    check("t5.ovf", 64'(overflow_out), 64'd0);
    $display("txn t5: power=0x%08h chan=%0d", power_out, chan_out);
    run = 1'b0;
    drive(16'hFFFF, 16'h0001, 2'd1, 1'b1);
    check("t5.run0.strobe", 64'(strobe_out), 64'd1);
    check("t5.run0.power", 64'(power_out), 64'hFFFF_0001);
    run = 1'b1;
    idle(); check_idle("t5.width");

    // Eight (-32768,-32768) samples: 8 * 2^31 = 2^34 overflows the 34-bit instance.
    wr(8'd0, 32'd0); wr(8'd1, 32'd8); wr(8'd2, 32'd1);
    repeat (8) drive(16'h8000, 16'h8000, 2'd0, 1'b1);
    repeat (3) begin idle(); check_idle("t6.lat"); end
    idle();
    check_out("t6", 32'hFFFF_FFFF, 2'd0, 1'b0, 32'h8000_0000);
    check("t6.s.strobe", 64'(strobe_s), 64'd1);
    check("t6.s.power", 64'(power_s), 64'hFFFF_FFFF);
    check("t6.s.ovf", 64'(ovf_s), 64'd1);
    check("t6.s.chan", 64'(chan_s_out), 64'd0);
    check("t6.s.peak", 64'(peak_s), PEAK_BUILT ? 64'h8000_0000 : 64'd0);
    $display("txn t6.s: power=0x%08h ovf=%0d", power_s, ovf_s);

    // Same period with scale=4: 2^30 on the wide instance, (2^34-1)>>4 on the narrow one.
    wr(8'd0, 32'd4);
    repeat (8) drive(16'h8000, 16'h8000, 2'd0, 1'b1);
    repeat (3) begin idle(); check_idle("t7.lat"); end
    idle();
    check_out("t7", 32'h4000_0000, 2'd0, 1'b0, 32'h8000_0000);
    check("t7.s.power", 64'(power_s), 64'h3FFF_FFFF);
    check("t7.s.ovf", 64'(ovf_s), 64'd1);

    // integrate=0 behaves as 1.
    wr(8'd0, 32'd0); wr(8'd1, 32'd0);
    drive(16'd5, 16'd0, 2'd1, 1'b1);
    repeat (3) begin idle(); check_idle("t8.lat"); end
    idle(); check_out("t8", 32'd25, 2'd1, 1'b0, 32'd25);

    // Shift beyond the accumulator width yields zero.
    wr(8'd0, 32'd50);
    drive(16'd100, 16'd0, 2'd2, 1'b1);
    repeat (3) begin idle(); check_idle("t9.lat"); end
    idle(); check_out("t9", 32'd0, 2'd2, 1'b0, 32'd10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
